input_scan_ctrl: RTL
====================

# input_scan_ctrl

Parametrised front-panel input conditioner. It scans a ROWS×COLS active-low key matrix and debounces every key and every slide switch against a shared frame tick. Key press and release events are queued in a first-word-fall-through (FWFT) FIFO with a valid/ready pop interface. A debounced reset button drives a long-press system reset. It sits between board pins and the CPU/peripheral bus, and generalises the fixed 5×4 scan, 16-switch, 200M-cycle reset input path.

## Interface
- SW_W, 16: number of slide switches.
- ROWS, 5: matrix rows driven (btn_x).
- COLS, 4: matrix columns sensed (btn_y).
- SCAN_DIV, 1000: clk cycles per row slot. Must be ≥ COLS+4.
- DB_SAMPLES, 4: consecutive equal frame samples needed to accept a new level. Range 2..15.
- HOLD_CYC, 200000000: cycles cr must be held before rst asserts.
- FIFO_DEPTH, 8: event FIFO entries. Must be a power of 2 and ≥ 2.
- KW = $clog2(ROWS*COLS), derived: key index width.

Ports:
- clk, in, 1: the single clock.
- RSTN, in, 1: reset, asynchronous, active-low.
- switch, in, SW_W: raw switches.
- rst_btn, in, 1: raw reset button, active-low.
- btn_x, out, ROWS: row drive, one-hot active-low.
- btn_y, in, COLS: column sense, active-low (0 = pressed).
- sw_ok, out, SW_W: debounced switch levels.
- btn_ok, out, ROWS*COLS: debounced key levels, 1 = pressed. Bit index = row*COLS+col.
- key_code, out, KW+1: FIFO head. Bit [KW] is 1 for press, 0 for release; bits [KW-1:0] are the key index.
- key_valid, out, 1: FIFO not empty.
- key_ready, in, 1: consumer pops on key_valid & key_ready.
- key_ovf, out, 1: sticky overflow flag.
- cr, out, 1: debounced reset-button level, 1 = pressed.
- rst, out, 1: long-press reset request.

## Operation
- Reset values: btn_x = ~1 (row 0 driven), all debounce states 0, sw_ok = 0, btn_ok = 0, cr = 0, rst = 0, key_valid = 0, key_ovf = 0. FIFO pointers 0, slot and row counters 0.
- Input synchronisation: btn_y, switch and rst_btn each pass through 2-flop synchronisers. rst_btn is inverted after synchronisation.
- Scan: slot counter runs 0..SCAN_DIV-1. At slot end, the row counter advances 0..ROWS-1 and wraps to 0. btn_x tracks the row counter.
- Key sampling: synchronised ~btn_y is sampled at slot count SCAN_DIV-1 for the current row.
- Frame tick: asserts for one cycle when the last row's slot ends.
- Key debounce, per key: a counter 0..DB_SAMPLES-1 that is updated only when that key's row is sampled.
  - If the sample equals the stable state, the counter clears.
  - Otherwise the counter increments. When it reaches DB_SAMPLES-1, the stable state flips and the counter clears.
- Switch and reset-button debounce: same algorithm, updated on each frame tick.
- Event generation: btn_ok bits that flip at a row sample are loaded into a COLS-bit pending vector.
  - One event is pushed per cycle, lowest column first, coded {new level, row*COLS+col}.
  - SCAN_DIV ≥ COLS+4 guarantees the pending vector drains before the next sample.
- FIFO: FWFT, so key_code is valid whenever key_valid = 1.
  - A push when full is dropped and sets key_ovf. key_ovf clears only on RSTN.
  - Push and pop in the same cycle: a push to a full FIFO succeeds when a pop occurs in that same cycle. Occupancy is unchanged.
  - A pop on an empty FIFO is ignored.
- Long press: a hold counter, width $clog2(HOLD_CYC+1).
  - While cr = 1, the counter increments and saturates at HOLD_CYC.
  - While cr = 0, the counter is 0.
  - rst = (counter == HOLD_CYC), registered. It drops the cycle after cr falls.
- Asserting RSTN mid-operation clears all state, including queued events and pending bits. Nothing resumes.

## Timing
- Row period: SCAN_DIV cycles. Frame period: ROWS*SCAN_DIV cycles.
- Key latency: a key held steady from before a sample gets its btn_ok edge at the DB_SAMPLES-th differing sample of its row, registered one cycle after that sample. This is at most DB_SAMPLES frames plus 3 cycles.
- Event latency: the event for column c becomes visible on key_valid/key_code c+2 cycles after the btn_ok edge, provided the FIFO was empty.
- Glitch rejection: a bounce shorter than DB_SAMPLES-1 consecutive samples never changes btn_ok, sw_ok or cr.
- rst rises exactly HOLD_CYC+1 cycles after cr rises.

## Test plan
Bench parameters: ROWS=2, COLS=2, SCAN_DIV=8, DB_SAMPLES=3, HOLD_CYC=10, FIFO_DEPTH=2.
- Reset: hold RSTN low mid-scan -> all outputs at reset values and btn_x=2'b10. After release, btn_x toggles every 8 cycles.
- Single press: model a matrix and press key 3 (row 1, col 1) for 5 frames -> btn_ok[3] rises after 3 row-1 samples, then key_code=3'b111 with key_valid. After release -> 3'b011.
- Bounce: key 0 pressed for 1 frame, released for 1 frame, pressed for 1 frame -> btn_ok stays 0 and no events.
- Simultaneous: keys 0 and 1 pressed together -> events 3'b100 then 3'b101 on consecutive pops.
- Overflow: with key_ready=0, press and release keys 0 and 1 -> FIFO holds the first 2 events, later events dropped, key_ovf=1. Pop with push in the same cycle succeeds when full.
- Long press: rst_btn=0 -> rst rises 11 cycles after cr rises. A press held 8 cycles gives no rst. On release, rst falls one cycle after cr.

Source files
------------

// File: rtl/input_scan_ctrl.sv
`default_nettype none
// ============================================================================
// input_scan_ctrl : key-matrix scanner, frame-tick debouncer, key event FIFO
//                   and long-press reset request for front-panel inputs.
// Revision        : 1.0 - initial release
// ============================================================================
module input_scan_ctrl #(
    parameter int SW_W       = 16,
    parameter int ROWS       = 5,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DB_SAMPLES = 4,
    parameter int HOLD_CYC   = 200000000,
    parameter int FIFO_DEPTH = 8,
    localparam int KW        = $clog2(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 RSTN,
    input  logic [SW_W-1:0]      switch,
    input  logic                 rst_btn,
    output logic [ROWS-1:0]      btn_x,
    input  logic [COLS-1:0]      btn_y,
    output logic [SW_W-1:0]      sw_ok,
    output logic [ROWS*COLS-1:0] btn_ok,
    output logic [KW:0]          key_code,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic                 key_ovf,
    output logic                 cr,
    output logic                 rst
);

    localparam int NK  = ROWS * COLS;
    localparam int SDW = $clog2(SCAN_DIV);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW  = 4;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int HW  = $clog2(HOLD_CYC + 1);

    function automatic logic [DW:0] db_step(input logic st, input logic [DW-1:0] cnt,
                                            input logic smp);
        logic [DW:0] res;
        if (smp == st)                       res = {st, DW'(0)};
        else if (cnt == DW'(DB_SAMPLES - 1)) res = {~st, DW'(0)};
        else                                 res = {st, cnt + DW'(1)};
        return res;
    endfunction

    logic [COLS-1:0] y_s1, y_s2;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic            rb_s1, rb_s2;
    logic [SDW-1:0]  slot;
    logic [RW-1:0]   row;
    logic            slot_end, frame_tick;

    logic [DW-1:0]   key_cnt [NK];
    logic [DW-1:0]   kcnt_nxt [NK];
    logic [NK-1:0]   ok_nxt;
    logic [DW-1:0]   sw_cnt [SW_W];
    logic [DW-1:0]   scnt_nxt [SW_W];
    logic [SW_W-1:0] sw_nxt;
    logic [DW-1:0]   cr_cnt, ccnt_nxt;
    logic            cr_nxt;
    logic [COLS-1:0] flips, lvls;

    logic [COLS-1:0] pend, pend_lvl;
    logic [RW-1:0]   pend_row;
    logic [CW-1:0]   col_idx;
    logic            scanning;
    logic            ev_valid;
    logic [KW:0]     ev_code;

    logic [KW:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, pop, push_ok;
    logic [HW-1:0]   hold_cnt;

    // Column sense idles high, so its synchroniser resets to the released level.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            y_s1  <= '1;
            y_s2  <= '1;
            sw_s1 <= '0;
            sw_s2 <= '0;
            rb_s1 <= 1'b1;
            rb_s2 <= 1'b1;
        end else begin
            y_s1  <= btn_y;
            y_s2  <= y_s1;
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
            rb_s1 <= rst_btn;
            rb_s2 <= rb_s1;
        end
    end

    assign slot_end   = (slot == SDW'(SCAN_DIV - 1));
    assign frame_tick = slot_end && (row == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            slot <= '0;
            row  <= '0;
        end else if (slot_end) begin
            slot <= '0;
            row  <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    always_comb begin
        btn_x = '1;
        for (int r = 0; r < ROWS; r++) btn_x[r] = (row != RW'(r));
    end

    always_comb begin
        ok_nxt   = btn_ok;
        kcnt_nxt = key_cnt;
        flips    = '0;
        lvls     = '0;
        sw_nxt   = sw_ok;
        scnt_nxt = sw_cnt;
        cr_nxt   = cr;
        ccnt_nxt = cr_cnt;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (slot_end && (row == RW'(r))) begin
                    {ok_nxt[r*COLS+c], kcnt_nxt[r*COLS+c]} =
                        db_step(btn_ok[r*COLS+c], key_cnt[r*COLS+c], ~y_s2[c]);
                    flips[c] = ok_nxt[r*COLS+c] ^ btn_ok[r*COLS+c];
                    lvls[c]  = ok_nxt[r*COLS+c];
                end
            end
        end
        if (frame_tick) begin
            for (int i = 0; i < SW_W; i++)
                {sw_nxt[i], scnt_nxt[i]} = db_step(sw_ok[i], sw_cnt[i], sw_s2[i]);
            {cr_nxt, ccnt_nxt} = db_step(cr, cr_cnt, ~rb_s2);
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            btn_ok <= '0;
            sw_ok  <= '0;
            cr     <= 1'b0;
            cr_cnt <= '0;
            for (int k = 0; k < NK; k++)   key_cnt[k] <= '0;
            for (int i = 0; i < SW_W; i++) sw_cnt[i]  <= '0;
        end else begin
            btn_ok  <= ok_nxt;
            key_cnt <= kcnt_nxt;
            sw_ok   <= sw_nxt;
            sw_cnt  <= scnt_nxt;
            cr      <= cr_nxt;
            cr_cnt  <= ccnt_nxt;
        end
    end

    // One column is examined per cycle after a row sample; hits go through a push register.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            pend     <= '0;
            pend_lvl <= '0;
            pend_row <= '0;
            col_idx  <= '0;
            scanning <= 1'b0;
            ev_valid <= 1'b0;
            ev_code  <= '0;
        end else if (slot_end) begin
            pend     <= flips;
            pend_lvl <= lvls;
            pend_row <= row;
            col_idx  <= '0;
            scanning <= |flips;
            ev_valid <= 1'b0;
        end else if (scanning) begin
            ev_valid <= pend[col_idx];
            ev_code  <= {pend_lvl[col_idx], KW'(int'(pend_row) * COLS + int'(col_idx))};
            col_idx  <= col_idx + 1'b1;
            if (col_idx == CW'(COLS - 1)) scanning <= 1'b0;
        end else begin
            ev_valid <= 1'b0;
        end
    end

    assign key_valid = (wr_ptr != rd_ptr);
    assign full      = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    assign push_ok   = ev_valid && (!full || pop);
    assign key_code  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            key_ovf <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= ev_code;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (ev_valid && !push_ok) key_ovf <= 1'b1;
        end
    end

    // Gating rst with cr lets it drop one cycle after the button is released.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            hold_cnt <= '0;
            rst      <= 1'b0;
        end else begin
            if (!cr)                            hold_cnt <= '0;
            else if (hold_cnt != HW'(HOLD_CYC)) hold_cnt <= hold_cnt + 1'b1;
            rst <= cr && (hold_cnt == HW'(HOLD_CYC));
        end
    end

endmodule
`default_nettype wire
